interval_timer_ctrl: RTL and testbench



---
 rtl/interval_timer_ctrl_pkg.sv | 18 +
 rtl/up_counter_4b.sv | 31 +++
 rtl/interval_timer_ctrl.sv | 116 +++++++++++
 tb/tb_interval_timer_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_ctrl_pkg.sv
// Shared types for the interval timer controller: state encoding, datapath width
// and a saturating decrement used by the interval down-counter.
package interval_timer_ctrl_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Saturates at zero so the interval count can never wrap.
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

endpackage

// File: rtl/up_counter_4b.sv
// 4-bit loadable up-counter datapath; ld has priority over cnt,
// tcount flags the all-ones terminal value.
module up_counter_4b (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic       cnt,
    input  logic [3:0] in,
    output logic [3:0] count,
    output logic       tcount
);

    logic [3:0] count_r;

    // Counter register: synchronous reset, load beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 4'd0;
        end else if (ld) begin
            count_r <= in;
        end else if (cnt) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count  = count_r;
    assign tcount = (count_r == 4'hF);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer: drives the 4-bit counter's ld/cnt/in pins to produce
// a tick every P+1 cycles for R intervals, then a one-cycle done pulse.
module interval_timer_ctrl
    import interval_timer_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] reps,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] count
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] period_nxt_s;
    logic [CNT_W-1:0] remaining_r;
    logic [CNT_W-1:0] remaining_nxt_s;
    logic [CNT_W-1:0] load_val_s;
    logic             ld_s;
    logic             cnt_s;
    logic             tick_s;
    logic             tcount_s;
    logic [CNT_W-1:0] count_s;

    up_counter_4b u_counter (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld_s),
        .cnt    (cnt_s),
        .in     (load_val_s),
        .count  (count_s),
        .tcount (tcount_s)
    );

    // Next-state, counter control and interval bookkeeping decode.
    always_comb begin
        state_nxt_s     = state_r;
        period_nxt_s    = period_r;
        remaining_nxt_s = remaining_r;
        load_val_s      = ~period_r;
        ld_s            = 1'b0;
        cnt_s           = 1'b0;
        tick_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // The first load must use the port value; period_r is only written at this edge.
                load_val_s = ~period;
                if (start) begin
                    if (reps != 4'd0) begin
                        ld_s            = 1'b1;
                        period_nxt_s    = period;
                        remaining_nxt_s = reps;
                        state_nxt_s     = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    remaining_nxt_s = 4'd0;
                    state_nxt_s     = ST_IDLE;
                end else if (pause) begin
                    state_nxt_s = ST_RUN;
                end else if (tcount_s) begin
                    tick_s          = 1'b1;
                    remaining_nxt_s = dec_sat(remaining_r);
                    if (remaining_r > 4'd1) begin
                        ld_s        = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    cnt_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state, latched period and interval down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            period_r    <= 4'd0;
            remaining_r <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            period_r    <= period_nxt_s;
            remaining_r <= remaining_nxt_s;
        end
    end

    assign busy      = (state_r == ST_RUN);
    assign done      = (state_r == ST_DONE);
    assign tick      = tick_s;
    assign remaining = remaining_r;
    assign count     = count_s;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl: stimulus queues expected tick/done events
// and per-cycle output snapshots; a negedge monitor pops and compares them.
module tb_interval_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] period;
    logic [3:0] reps;
    logic       pause;
    logic       abort;
    logic       busy;
    logic       tick;
    logic       done;
    logic [3:0] remaining;
    logic [3:0] count;

    typedef struct {
        int         at;
        logic       is_done;
        logic [3:0] rem;
    } ev_t;

    typedef struct {
        int          at;
        logic [10:0] exp;
        string       name;
    } probe_t;

    ev_t    ev_q[$];
    probe_t probe_q[$];

    int   edges   = 0;
    int   checks  = 0;
    int   fails   = 0;
    int   base    = 0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    interval_timer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .period    (period),
        .reps      (reps),
        .pause     (pause),
        .abort     (abort),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .remaining (remaining),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edges <= edges + 1;

    // Monitor: snapshot probes, tick/done events and end-of-run drain check.
    always @(negedge clk) begin
        logic [10:0] act;
        probe_t      p;
        ev_t         e;
        act = {busy, tick, done, remaining, count};
        if (probe_q.size() > 0 && probe_q[0].at <= edges) begin
            p = probe_q.pop_front();
            checks++;
            if (p.at != edges) begin
                fails++;
                $display("FAIL %s: probe for cycle %0d not taken (now %0d)", p.name, p.at, edges);
            end else if (act !== p.exp) begin
                fails++;
                $display("FAIL %s: {busy,tick,done,rem,cnt} got %b required %b", p.name, act, p.exp);
            end
        end
        if (ev_q.size() > 0 && ev_q[0].at < edges) begin
            e = ev_q.pop_front();
            checks++;
            fails++;
            $display("FAIL missed_event: got nothing at cycle %0d required %s", e.at, e.is_done ? "done" : "tick");
        end
        if (tick === 1'b1 || done === 1'b1) begin
            checks++;
            if (ev_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got tick=%b done=%b at cycle %0d required none", tick, done, edges);
            end else begin
                e = ev_q.pop_front();
                if (e.at != edges || done !== e.is_done || tick !== !e.is_done || remaining !== e.rem) begin
                    fails++;
                    $display("FAIL event: got cyc=%0d tick=%b done=%b rem=%0d required cyc=%0d %s rem=%0d",
                             edges, tick, done, remaining, e.at, e.is_done ? "done" : "tick", e.rem);
                end
            end
        end
        if (end_req && !end_ack) begin
            checks++;
            if (ev_q.size() != 0 || probe_q.size() != 0) begin
                fails++;
                $display("FAIL drain: got %0d events %0d probes left required 0 0", ev_q.size(), probe_q.size());
            end
            end_ack = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (edges < t) step();
    endtask

    task automatic probe(input int rel, input logic b, input logic t, input logic d,
                         input logic [3:0] rem, input logic [3:0] cnt, input string name);
        probe_t p;
        p.at   = base + rel;
        p.exp  = {b, t, d, rem, cnt};
        p.name = name;
        probe_q.push_back(p);
    endtask

    task automatic expect_ev(input int rel, input logic is_done, input logic [3:0] rem);
        ev_t e;
        e.at      = base + rel;
        e.is_done = is_done;
        e.rem     = rem;
        ev_q.push_back(e);
    endtask

    task automatic launch(input logic [3:0] p, input logic [3:0] r);
        start  = 1'b1;
        period = p;
        reps   = r;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; period = 4'd0; reps = 4'd0; pause = 1'b0; abort = 1'b0;
        step();
        base = edges;
        probe(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, "reset_state");
        rst = 1'b0;
        step();

        // P=3 R=2: ticks 4 and 8, done 9
        step(); base = edges;
        probe(1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd12, "p3_load");
        probe(4, 1'b1, 1'b1, 1'b0, 4'd2, 4'd15, "p3_tick1");
        probe(5, 1'b1, 1'b0, 1'b0, 4'd1, 4'd12, "p3_reload");
        probe(8, 1'b1, 1'b1, 1'b0, 4'd1, 4'd15, "p3_tick2");
        probe(9, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, "p3_done");
        probe(10, 1'b0, 1'b0, 1'b0, 4'd0, 4'd15, "p3_idle");
        expect_ev(4, 1'b0, 4'd2); expect_ev(8, 1'b0, 4'd1); expect_ev(9, 1'b1, 4'd0);
        launch(4'd3, 4'd2);
        step(); start = 1'b0;
        goto(base + 11);

        // P=0 R=3: tick every cycle 1..3, done 4
        base = edges;
        probe(1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd15, "p0_tick1");
        probe(2, 1'b1, 1'b1, 1'b0, 4'd2, 4'd15, "p0_tick2");
        probe(3, 1'b1, 1'b1, 1'b0, 4'd1, 4'd15, "p0_tick3");
        probe(4, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, "p0_done");
        expect_ev(1, 1'b0, 4'd3); expect_ev(2, 1'b0, 4'd2); expect_ev(3, 1'b0, 4'd1); expect_ev(4, 1'b1, 4'd0);
        launch(4'd0, 4'd3);
        step(); start = 1'b0;
        goto(base + 6);

        // P=2 R=1, pause in cycles 2-3: tick 5, done 6
        base = edges;
        probe(2, 1'b1, 1'b0, 1'b0, 4'd1, 4'd14, "pause_hold1");
        probe(3, 1'b1, 1'b0, 1'b0, 4'd1, 4'd14, "pause_hold2");
        probe(4, 1'b1, 1'b0, 1'b0, 4'd1, 4'd14, "pause_resume");
        probe(5, 1'b1, 1'b1, 1'b0, 4'd1, 4'd15, "pause_tick");
        probe(6, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, "pause_done");
        expect_ev(5, 1'b0, 4'd1); expect_ev(6, 1'b1, 4'd0);
        launch(4'd2, 4'd1);
        step(); start = 1'b0;
        step(); pause = 1'b1;
        step();
        step(); pause = 1'b0;
        goto(base + 8);

        // P=0 R=1, pause while at terminal count suppresses the tick
        base = edges;
        probe(1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd15, "pause_at_tc");
        probe(2, 1'b1, 1'b1, 1'b0, 4'd1, 4'd15, "pause_tc_tick");
        probe(3, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, "pause_tc_done");
        expect_ev(2, 1'b0, 4'd1); expect_ev(3, 1'b1, 4'd0);
        launch(4'd0, 4'd1);
        step(); start = 1'b0; pause = 1'b1;
        step(); pause = 1'b0;
        goto(base + 5);

        // P=5 R=4, abort with pause in cycle 3
        base = edges;
        probe(3, 1'b1, 1'b0, 1'b0, 4'd4, 4'd12, "abort_cycle");
        probe(4, 1'b0, 1'b0, 1'b0, 4'd0, 4'd12, "abort_idle");
        probe(7, 1'b0, 1'b0, 1'b0, 4'd0, 4'd12, "abort_quiet");
        launch(4'd5, 4'd4);
        step(); start = 1'b0;
        step();
        step(); abort = 1'b1; pause = 1'b1;
        step(); abort = 1'b0; pause = 1'b0;
        goto(base + 9);

        // reps=0: done in cycle 1, counter untouched
        base = edges;
        probe(1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd12, "reps0_done");
        probe(2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd12, "reps0_idle");
        expect_ev(1, 1'b1, 4'd0);
        launch(4'd7, 4'd0);
        step(); start = 1'b0;
        goto(base + 4);

        // start re-asserted in cycles 2-6 with other operands is ignored
        base = edges;
        probe(4, 1'b1, 1'b1, 1'b0, 4'd2, 4'd15, "restart_tick1");
        probe(5, 1'b1, 1'b0, 1'b0, 4'd1, 4'd12, "restart_reload");
        probe(9, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, "restart_done");
        expect_ev(4, 1'b0, 4'd2); expect_ev(8, 1'b0, 4'd1); expect_ev(9, 1'b1, 4'd0);
        launch(4'd3, 4'd2);
        step(); start = 1'b0;
        step(); launch(4'd9, 4'd5);
        goto(base + 7); start = 1'b0;
        goto(base + 11);

        // rst in cycle 3 of a run
        base = edges;
        probe(2, 1'b1, 1'b0, 1'b0, 4'd2, 4'd12, "rst_before");
        probe(4, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, "rst_cleared");
        probe(6, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, "rst_stays_idle");
        launch(4'd4, 4'd2);
        step(); start = 1'b0;
        goto(base + 3); rst = 1'b1;
        step(); rst = 1'b0;
        goto(base + 8);

        // P=15 R=1: loads 0, tick in cycle 16
        base = edges;
        probe(1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, "p15_load");
        probe(16, 1'b1, 1'b1, 1'b0, 4'd1, 4'd15, "p15_tick");
        probe(17, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, "p15_done");
        expect_ev(16, 1'b0, 4'd1); expect_ev(17, 1'b1, 4'd0);
        launch(4'd15, 4'd1);
        step(); start = 1'b0;
        goto(base + 20);

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) step();
        if (!end_ack) begin
            $display("FAIL monitor_timeout: got no drain acknowledge required one within 10 cycles");
            $fatal(1, "monitor did not respond");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
